// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops in a single cycle at accept.
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_invalidate,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_rd_data,
   output logic [4:0]      o_rd_addr,
   output logic            o_busy
);
   localparam int K  = XLEN / UNROLL;
   localparam int CW = K > 1 ? $clog2(K) : 1;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t            r_state, w_next;
   logic [2:0]        r_op;
   logic [4:0]        r_rd, r_rd_out;
   logic [CW-1:0]     r_cnt;
   logic              r_neg, r_aneg, r_spec;
   logic [2*XLEN-1:0] r_acc, w_init, w_step, w_prod;
   logic [XLEN-1:0]   r_b, r_data, w_abs_a, w_abs_b, w_spec_res, w_fix, w_quo, w_rem;
   logic [XLEN:0]     w_sum, w_diff;
   logic              w_accept, w_asg, w_bsg, w_aneg, w_bneg, w_bz, w_ovf, w_special;
   assign w_accept   = i_valid & (r_state == IDLE) & ~i_invalidate;
   assign w_asg      = i_op[2] ? ~i_op[0] : (i_op[1] ^ i_op[0]);
   assign w_bsg      = i_op[2] ? ~i_op[0] : (i_op == 3'd1);
   assign w_aneg     = w_asg & i_operand_a[XLEN-1];
   assign w_bneg     = w_bsg & i_operand_b[XLEN-1];
   assign w_abs_a    = w_aneg ? -i_operand_a : i_operand_a;
   assign w_abs_b    = w_bneg ? -i_operand_b : i_operand_b;
   assign w_bz       = i_operand_b == '0;
   assign w_ovf      = ~i_op[0] & (i_operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_operand_b);
   assign w_special  = i_op[2] & (w_bz | w_ovf);
   assign w_spec_res = i_op[1] ? (w_bz ? i_operand_a : '0) : (w_bz ? '1 : i_operand_a);
`ifdef MULDIV_FAST_MUL_EN
   logic w_fast;
   assign w_fast = ~i_op[2];
   assign w_init = w_special ? {{XLEN{1'b0}}, w_spec_res}
                 : w_fast    ? {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b}
                 :             {{XLEN{1'b0}}, w_abs_a};
`else
   logic w_fast;
   assign w_fast = 1'b0;
   assign w_init = w_special ? {{XLEN{1'b0}}, w_spec_res} : {{XLEN{1'b0}}, w_abs_a};
`endif
   // r_acc holds {hi, lo} of the product, or {remainder, quotient} while dividing
   always_comb begin
      w_step = r_acc;
      w_sum  = '0;
      w_diff = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (r_op[2]) begin
            w_diff = w_step[2*XLEN-1:XLEN-1] - {1'b0, r_b};
            w_step = w_diff[XLEN] ? {w_step[2*XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], w_step[XLEN-2:0], 1'b1};
         end else begin
            w_sum  = {1'b0, w_step[2*XLEN-1:XLEN]} + {1'b0, {XLEN{w_step[0]}} & r_b};
            w_step = {w_sum, w_step[XLEN-1:1]};
         end
      end
   end
   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_rem  = r_acc[2*XLEN-1:XLEN];
   assign w_quo  = r_acc[XLEN-1:0];
   assign w_fix  = r_spec           ? r_acc[XLEN-1:0]
                 : ~r_op[2]         ? (r_op[1:0] == 2'd0 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                 : r_op[1]          ? (r_aneg ? -w_rem : w_rem)
                 :                    (r_neg ? -w_quo : w_quo);
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next = (w_special | w_fast) ? FIX : CALC;
         CALC: if (r_cnt == '0) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: if (i_ready) w_next = IDLE;
      endcase
      if (i_invalidate) w_next = IDLE;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_data   <= '0;
         r_rd_out <= '0;
         r_op     <= '0;
         r_rd     <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_aneg   <= 1'b0;
         r_spec   <= 1'b0;
         r_acc    <= '0;
         r_b      <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= i_op;
            r_rd   <= i_rd_addr;
            r_cnt  <= CW'(K - 1);
            r_neg  <= w_aneg ^ w_bneg;
            r_aneg <= w_aneg;
            r_spec <= w_special;
            r_acc  <= w_init;
            r_b    <= w_abs_b;
         end else if (r_state == CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_state == FIX) begin
            r_data   <= w_fix;
            r_rd_out <= r_rd;
         end
      end
   end
   assign o_ready   = r_state == IDLE;
   assign o_busy    = r_state != IDLE;
   assign o_valid   = r_state == DONE;
   assign o_rd_data = r_data;
   assign o_rd_addr = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at UNROLL=1 and UNROLL=4.
module tb_muldiv_unit;
   logic        clk = 0, rst = 1, valid = 0, inv = 0, rdy = 1, s = 0;
   logic [2:0]  op = 0;
   logic [31:0] a = 0, b = 0;
   logic [4:0]  rd = 0;
   logic        r0, r1, v0, v1, bz0, bz1;
   logic [31:0] d0, d1;
   logic [4:0]  ad0, ad1;
   int          checks = 0, errors = 0;
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1;
`else
   localparam bit FAST = 0;
`endif
   always #5 clk = ~clk;
   muldiv_unit #(.XLEN(32), .UNROLL(1)) u0 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid & ~s), .o_ready(r0), .i_op(op),
      .i_operand_a(a), .i_operand_b(b), .i_rd_addr(rd), .i_invalidate(inv & ~s),
      .o_valid(v0), .i_ready(rdy), .o_rd_data(d0), .o_rd_addr(ad0), .o_busy(bz0));
   muldiv_unit #(.XLEN(32), .UNROLL(4)) u1 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid & s), .o_ready(r1), .i_op(op),
      .i_operand_a(a), .i_operand_b(b), .i_rd_addr(rd), .i_invalidate(inv & s),
      .o_valid(v1), .i_ready(rdy), .o_rd_data(d1), .o_rd_addr(ad1), .o_busy(bz1));
   wire        m_v = s ? v1 : v0;
   wire        m_r = s ? r1 : r0;
   wire        m_b = s ? bz1 : bz0;
   wire [31:0] m_d = s ? d1 : d0;
   wire [4:0]  m_a = s ? ad1 : ad0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s unroll_sel=%0d observed=%0h expected=%0h", tag, s, obs, exp);
      end
   endtask
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
      @(negedge clk);
      op = o; a = x; b = y; rd = r; valid = 1;
      @(negedge clk);
      valid = 0; a = $urandom; b = $urandom; op = 3'($urandom); rd = 5'($urandom);
   endtask
   task automatic wait_v(output int n);
      n = 0;
      while (!m_v && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input int lat, input logic [4:0] r);
      int n;
      issue(o, x, y, r);
      wait_v(n);
      chk({tag, " latency"}, n, lat);
      chk({tag, " data"}, m_d, exp);
      chk({tag, " rd"}, m_a, r);
      @(negedge clk);
      chk({tag, " ready"}, m_r, 1);
   endtask
   task automatic seq(input int lat);
      int n;
      int ml;
      ml = FAST ? 1 : lat;
      run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ml, 5'd1);
      run("div", 3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, lat, 5'd2);
      run("rem", 3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, lat, 5'd3);
      run("divu0", 3'd5, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 5'd4);
      run("remu0", 3'd7, 32'd123, 32'd0, 32'd123, 1, 5'd5);
      run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 5'd6);
      run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 5'd7);
      run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ml, 5'd8);
      run("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, ml, 5'd10);
      run("divu", 3'd5, 32'd100, 32'd7, 32'd14, lat, 5'd12);
      run("remu", 3'd7, 32'd100, 32'd7, 32'd2, lat, 5'd13);
      run("mul_neg", 3'd0, -32'sd5, 32'd3, 32'hFFFF_FFF1, ml, 5'd14);
      rdy = 0;
      issue(3'd0, 32'd6, 32'd7, 5'd9);
      wait_v(n);
      chk("hold latency", n, ml);
      valid = 1; op = 3'd5; a = 32'd5; b = 32'd0; rd = 5'd20;
      for (int i = 0; i < 5; i++) begin
         chk("hold valid", m_v, 1);
         chk("hold data", m_d, 32'd42);
         chk("hold rd", m_a, 5'd9);
         chk("hold ready", m_r, 0);
         @(negedge clk);
      end
      valid = 0; rdy = 1;
      @(negedge clk);
      chk("release valid", m_v, 0);
      chk("release ready", m_r, 1);
      issue(3'd4, 32'd1000, 32'd3, 5'd11);
      repeat (9) @(negedge clk);
      inv = 1;
      @(negedge clk);
      inv = 0;
      chk("flush valid", m_v, 0);
      chk("flush ready", m_r, 1);
      chk("flush busy", m_b, 0);
      valid = 1; inv = 1; op = 3'd5; b = 32'd0;
      @(negedge clk);
      valid = 0; inv = 0;
      chk("flush prio ready", m_r, 1);
      chk("flush prio busy", m_b, 0);
      run("mulh_post", 3'd1, -32'sd2, 32'd3, 32'hFFFF_FFFF, ml, 5'd15);
      issue(3'd4, 32'd1000, 32'd3, 5'd16);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst valid", m_v, 0);
      chk("midrst data", m_d, 0);
      chk("midrst rd", m_a, 0);
      chk("midrst ready", m_r, 1);
      chk("midrst busy", m_b, 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         s = i[0];
         chk("reset valid", m_v, 0);
         chk("reset data", m_d, 0);
         chk("reset rd", m_a, 0);
         chk("reset busy", m_b, 0);
         chk("reset ready", m_r, 1);
      end
      s = 0;
      seq(33);
      s = 1;
      seq(9);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
